// File: rtl/cpu_mult_pipe.sv
// Three-stage pipelined DATA_W x DATA_W multiplier with signed/unsigned/mixed modes,
// low/high half select, per-operation valid and tag, stall (en) and flush.
module cpu_mult_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [1:0]        op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam int H = DATA_W / 2;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULXUU = 2'b01,
    OP_MULXSU = 2'b10,
    OP_MULXSS = 2'b11
  } op_e;

  // Stage 1: registered operands
  logic [DATA_W-1:0] a1, b1;
  op_e               op1;
  logic [TAG_W-1:0]  tag1;
  logic              v1;

  // Stage 2: partial products and sign correction
  logic [DATA_W-1:0] pll, plh, phl, phh, corr2;
  op_e               op2;
  logic [TAG_W-1:0]  tag2;
  logic              v2;

  logic [DATA_W-1:0] al, ah, bl, bh;
  logic [DATA_W-1:0] corr_c;
  logic              a_signed, b_signed;
  logic [2*DATA_W-1:0] p_c;

  always_comb begin
    al = {{H{1'b0}}, a1[H-1:0]};
    ah = {{H{1'b0}}, a1[DATA_W-1:H]};
    bl = {{H{1'b0}}, b1[H-1:0]};
    bh = {{H{1'b0}}, b1[DATA_W-1:H]};
    a_signed = (op1 == OP_MULXSU) || (op1 == OP_MULXSS);
    b_signed = (op1 == OP_MULXSS);
    // Both corrections land in the upper half only, so their sum is kept modulo 2^DATA_W.
    corr_c = ((a_signed && a1[DATA_W-1]) ? b1 : '0)
           + ((b_signed && b1[DATA_W-1]) ? a1 : '0);
  end

  always_comb begin
    p_c = {{DATA_W{1'b0}}, pll}
        + {{H{1'b0}}, plh, {H{1'b0}}}
        + {{H{1'b0}}, phl, {H{1'b0}}}
        + {phh, {DATA_W{1'b0}}}
        - {corr2, {DATA_W{1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
    end else begin
      if (en) begin
        a1        <= src1;
        b1        <= src2;
        op1       <= op_e'(op);
        tag1      <= in_tag;
        v1        <= in_valid;

        pll       <= al * bl;
        plh       <= al * bh;
        phl       <= ah * bl;
        phh       <= ah * bh;
        corr2     <= corr_c;
        op2       <= op1;
        tag2      <= tag1;
        v2        <= v1;

        result    <= (op2 == OP_MUL) ? p_c[DATA_W-1:0] : p_c[2*DATA_W-1:DATA_W];
        out_tag   <= tag2;
        out_valid <= v2;
      end
      // Flush overrides the enable so in-flight valids die even during a stall.
      if (flush) begin
        v1        <= 1'b0;
        v2        <= 1'b0;
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = v1 | v2 | out_valid;

endmodule
